riscv_dmem_responder: RTL and testbench

//  Responder end of the core's data-memory load/store channel. Accepts one request
//  at a time over a VALID/READY request channel, applies WAIT_CYC wait states and

---
 rtl/riscv_dmem_responder.sv | 123 ++++++++++++
 tb/tb_riscv_dmem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: one request at a time over VALID/READY, WAIT_CYC wait states,
// then a word load or byte-masked store on a local array, answered over VALID/READY.
module riscv_dmem_responder #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    input  logic [3:0]  REQ_BE,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam bit         NoWait  = (WAIT_CYC == 0);
    localparam logic [3:0] LastCnt = NoWait ? 4'd0 : 4'(WAIT_CYC - 1);

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_mem [2**ADDR_W];

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_acc_we;
    logic [31:0]       w_acc_addr;
    logic [31:0]       w_acc_wdata;
    logic [3:0]        w_acc_be;
    logic [ADDR_W-1:0] w_idx;
    logic              w_err;
    logic              w_mem_wr;
    logic [31:0]       w_rd_data;

    assign w_accept     = (r_state == StIdle) && r_req_ready && REQ_VALID;
    assign w_enter_resp = (NoWait && w_accept) || ((r_state == StWait) && (r_cnt == LastCnt));

    // With zero wait states the access happens on the accept edge, so use the live request
    assign w_acc_we    = (r_state == StIdle) ? REQ_WE    : r_we;
    assign w_acc_addr  = (r_state == StIdle) ? REQ_ADDR  : r_addr;
    assign w_acc_wdata = (r_state == StIdle) ? REQ_WDATA : r_wdata;
    assign w_acc_be    = (r_state == StIdle) ? REQ_BE    : r_be;

    assign w_idx     = w_acc_addr[ADDR_W+1:2];
    assign w_err     = (|w_acc_addr[1:0]) | (|w_acc_addr[31:ADDR_W+2]);
    assign w_mem_wr  = w_enter_resp & w_acc_we & ~w_err;
    assign w_rd_data = (w_acc_we | w_err) ? 32'd0 : r_mem[w_idx];

    always_ff @(posedge CLK) begin
        if (w_mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_be[i]) r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_be        <= 4'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_we        <= REQ_WE;
                        r_addr      <= REQ_ADDR;
                        r_wdata     <= REQ_WDATA;
                        r_be        <= REQ_BE;
                        r_cnt       <= 4'd0;
                        r_req_ready <= 1'b0;
                        r_state     <= StWait;
                    end
                end
                StWait: begin
                    if (!w_enter_resp) r_cnt <= r_cnt + 4'd1;
                end
                StResp: begin
                    if (RSP_READY) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
            // Overrides the per-state next state above when the response is due
            if (w_enter_resp) begin
                r_state     <= StResp;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= w_rd_data;
            end
        end
    end

    assign REQ_READY = r_req_ready;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_RDATA = r_rsp_rdata;
    assign RSP_ERR   = r_rsp_err;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench for riscv_dmem_responder: a WAIT_CYC=2 and a WAIT_CYC=0 instance checked against
// a word-array model with directed and random load/store traffic.
module tb_riscv_dmem_responder;

    localparam int unsigned AddrW = 10;
    localparam int unsigned Depth = 1 << AddrW;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;  // 0 selects the WAIT_CYC=2 instance, 1 the WAIT_CYC=0 instance
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;

    logic        rr2, rv2, re2, rr0, rv0, re0;
    logic [31:0] rd2, rd0;
    logic        w_req_ready, w_rsp_valid, w_rsp_err;
    logic [31:0] w_rsp_rdata;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int          cyc = 0;
    int          end_cyc = -10;
    int          last_rsp_cyc = 0;
    bit          prev_early = 1'b0;
    logic [31:0] mdl [2][Depth];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_dmem_responder #(.ADDR_W(AddrW), .WAIT_CYC(2)) u_dut2 (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid & ~sel), .REQ_READY(rr2),
        .REQ_WE(req_we), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_BE(req_be),
        .RSP_VALID(rv2), .RSP_READY(rsp_ready), .RSP_RDATA(rd2), .RSP_ERR(re2)
    );

    riscv_dmem_responder #(.ADDR_W(AddrW), .WAIT_CYC(0)) u_dut0 (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid & sel), .REQ_READY(rr0),
        .REQ_WE(req_we), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_BE(req_be),
        .RSP_VALID(rv0), .RSP_READY(rsp_ready), .RSP_RDATA(rd0), .RSP_ERR(re0)
    );

    assign w_req_ready = sel ? rr0 : rr2;
    assign w_rsp_valid = sel ? rv0 : rv2;
    assign w_rsp_rdata = sel ? rd0 : rd2;
    assign w_rsp_err   = sel ? re0 : re2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Starts and ends on a negedge. hold<0: RSP_READY raised with the request,
    // otherwise RSP_READY held low for 'hold' cycles of RSP_VALID.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold, output logic [31:0] got);
        int          w;
        int          n;
        bit          contig;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] word;
        w      = sel ? 0 : 2;
        got    = 32'hx;
        contig = (cyc == end_cyc) && prev_early && (hold < 0);
        n = 0;
        while (!w_req_ready && n < 50) begin @(negedge clk); n++; end
        if (!w_req_ready) begin chk("req_ready_timeout", 32'(w_req_ready), 32'd1); return; end

        exp_err = (addr[1:0] != 2'b00) || (addr[31:2] >= Depth);
        exp_rd  = (we || exp_err) ? 32'd0 : mdl[sel][addr[AddrW+1:2]];
        if (we && !exp_err) begin
            word = mdl[sel][addr[AddrW+1:2]];
            for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
            mdl[sel][addr[AddrW+1:2]] = word;
        end

        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        rsp_ready = (hold < 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = $urandom; req_addr = $urandom;
        req_wdata = $urandom; req_be = 4'($urandom);
        n = 1;
        @(negedge clk);
        while (!w_rsp_valid && n < 50) begin
            chk("req_ready_busy", 32'(w_req_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        if (!w_rsp_valid) begin chk("rsp_valid_timeout", 32'(w_rsp_valid), 32'd1); return; end
        chk("latency", 32'(n), 32'(w + 1));
        if (contig) chk("throughput", 32'(cyc - last_rsp_cyc), 32'(w + 2));
        last_rsp_cyc = cyc;
        chk("rdata", w_rsp_rdata, exp_rd);
        chk("err", 32'(w_rsp_err), 32'(exp_err));
        got = w_rsp_rdata;
        if (hold >= 0) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk("hold_valid", 32'(w_rsp_valid), 32'd1);
                chk("hold_rdata", w_rsp_rdata, exp_rd);
                chk("hold_req_ready", 32'(w_req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk("valid_drop", 32'(w_rsp_valid), 32'd0);
        chk("ready_back", 32'(w_req_ready), 32'd1);
        rsp_ready  = 1'b0;
        prev_early = (hold < 0);
        end_cyc    = cyc;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        int          hold;
        bit          seen;
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready2", 32'(rr2), 32'd1);
        chk("rst_rsp_valid2", 32'(rv2), 32'd0);
        chk("rst_rdata2", rd2, 32'd0);
        chk("rst_err0", 32'(re0), 32'd0);
        chk("rst_req_ready0", 32'(rr0), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Fill both arrays so every later load has a known expected value
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < int'(Depth); i++) txn(1'b1, 32'(i) << 2, $urandom, 4'hF, -1, got);
        end

        sel = 1'b0;
        txn(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 0, got);
        txn(1'b0, 32'h40, 32'h0, 4'h0, 0, got);
        chk("t1_load", got, 32'hDEADBEEF);

        txn(1'b1, 32'h10, 32'h11223344, 4'hF, -1, got);
        txn(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, -1, got);
        txn(1'b0, 32'h10, 32'h0, 4'hF, -1, got);
        chk("t2_mask", got, 32'h11BB33DD);
        txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1, got);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 1, got);
        chk("be_zero_noop", got, 32'h11BB33DD);

        txn(1'b0, 32'h41, 32'h0, 4'hF, 0, got);
        chk("t3_misaligned_rdata", got, 32'd0);
        txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, got);
        txn(1'b1, 32'(4 << AddrW), 32'h12345678, 4'hF, 0, got);
        txn(1'b0, 32'h0, 32'h0, 4'hF, 0, got);
        chk("t3_range_unchanged", got, 32'hCAFEF00D);

        txn(1'b0, 32'h40, 32'h0, 4'h0, 5, got);

        // Reset during the wait states of a store
        txn(1'b1, 32'h20, 32'h1234ABCD, 4'hF, 0, got);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55; req_be = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_req_ready", 32'(rr2), 32'd1);
        chk("t6_rsp_valid", 32'(rv2), 32'd0);
        chk("t6_rdata", rd2, 32'd0);
        chk("t6_err", 32'(re2), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin @(negedge clk); seen |= rv2; end
        chk("t6_no_response", 32'(seen), 32'd0);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, got);
        chk("t6_old_value", got, 32'h1234ABCD);

        sel = 1'b1;
        txn(1'b1, 32'h80, 32'h0BADF00D, 4'hF, -1, got);
        txn(1'b0, 32'h80, 32'h0, 4'h0, -1, got);
        chk("t5_load", got, 32'h0BADF00D);
        txn(1'b0, 32'h43, 32'h0, 4'h0, -1, got);
        txn(1'b1, 32'h84, 32'hA5A5A5A5, 4'b1010, 2, got);

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 1);
            case ($urandom_range(0, 7))
                0:       a = $urandom;
                1:       a = {20'd0, $urandom_range(0, Depth - 1), 2'($urandom_range(1, 3))};
                default: a = {20'd0, 4'($urandom_range(0, 3)), 6'($urandom), 2'b00};
            endcase
            hold = $urandom_range(0, 3) - 1;
            txn($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom), hold, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
